instr_aligner: RTL and testbench
================================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC of the first instruction after reset.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port fetch_req_o  output  1  word-fetch request to instruction memory.
REQ-005 SHALL have port fetch_addr_o  output  32  word-aligned fetch address, bits [1:0] always 0.
REQ-006 SHALL have port fetch_valid_i  input  1  response strobe for the outstanding request.
REQ-007 SHALL have port fetch_data_i  input  32  fetched word, halfword 0 in bits [15:0].
REQ-008 SHALL have port redirect_i  input  1  branch/jump flush.
REQ-009 SHALL have port redirect_pc_i  input  32  new PC, halfword aligned.
REQ-010 SHALL have port valid_o  output  1  instr_o/pc_o/decompress_o hold a complete instruction.
REQ-011 SHALL have port ready_i  input  1  downstream accepts; transfer when valid_o and ready_i are both high.
REQ-012 SHALL have port instr_o  output  32  instruction, 16-bit forms zero-extended to {16'b0, hw}.
REQ-013 SHALL have port decompress_o  output  1  instr_o is a 16-bit compressed instruction; drives the decompressor's decompress_i.
REQ-014 SHALL have port pc_o  output  32  PC of instr_o.

Function
REQ-015 SHALL buffer up to 4 halfwords in a FIFO with a count register (0..4) and head-first ordering.
REQ-016 SHALL classify the head halfword as 16-bit when bits [1:0] != 2'b11, and as 32-bit otherwise.
REQ-017 SHALL assert valid_o when count>=1 with a 16-bit head, or when count>=2; otherwise valid_o=0.
REQ-018 SHALL pop 1 halfword and add 2 to pc_o on a 16-bit transfer, and SHALL pop 2 and add 4 on a 32-bit transfer.
REQ-019 SHALL run a fetch FSM with states RUN (none outstanding), WAIT (one outstanding), and DROP (outstanding response to be discarded).
REQ-020 In RUN, when count<=2 and redirect_i=0, SHALL pulse fetch_req_o for one cycle, go to WAIT, and advance fetch_addr_o by 4 on the following cycle.
REQ-021 In WAIT, on fetch_valid_i SHALL append the 2 halfwords in the same edge as any pop and return to RUN.
REQ-022 On the first response after a redirect with redirect_pc_i[1]=1, SHALL append only halfword 1.
REQ-023 In DROP, on fetch_valid_i SHALL discard the data and go to RUN; fetch_valid_i in RUN SHALL be ignored.
REQ-024 On redirect_i, SHALL set count=0, pc_o=redirect_pc_i, and fetch_addr_o={redirect_pc_i[31:2],2'b00}.
REQ-025 On redirect_i, SHALL go WAIT->DROP, remain DROP if already in DROP, and stay in RUN from RUN with no request that cycle.
REQ-026 On redirect_i, SHALL suppress any push and pop that cycle and drive valid_o=0 the next cycle; redirect_i SHALL have priority over all other events.
REQ-027 SHALL keep a 32-bit instruction split across two fetched words invisible downstream (valid_o=0) until both halves are buffered.
REQ-028 SHALL hold valid_o, instr_o, pc_o and decompress_o stable while valid_o=1 and ready_i=0.

Reset
REQ-029 Reset SHALL drive: count=0, FSM=RUN, pc_o=RESET_PC, fetch_addr_o={RESET_PC[31:2],2'b00}, valid_o=0, fetch_req_o=0, instr_o=0, decompress_o=0.
REQ-030 A response arriving during or after a mid-fetch reset SHALL be discarded, because the FSM is in RUN.
REQ-031 The first fetch_req_o SHALL occur in the cycle after rst_i deasserts.

Configuration
REQ-032 With macro INSTR_ALIGNER_COMPRESSED_EN defined, SHALL behave as specified above.
REQ-033 With INSTR_ALIGNER_COMPRESSED_EN undefined:
  - SHALL treat every instruction as 32-bit and pop 2 halfwords per transfer;
  - SHALL tie decompress_o=0;
  - SHALL ignore redirect_pc_i[1] and bit 1 of RESET_PC.

Verification
REQ-034 Reset, then memory returns 32'h0001_4501 one cycle after the request -> instr_o=32'h0000_4501, decompress_o=1, pc_o=0; then instr_o=32'h0000_0001, pc_o=2.
REQ-035 Word0=32'h0093_4501, word1=32'h0000_0000 (32'h0000_0093 spans the words) -> 32'h0000_4501 @pc 0, then 32'h0000_0093 @pc 2 only after word1 arrives.
REQ-036 redirect_i with redirect_pc_i=32'h0000_0106 while in WAIT -> old response discarded; next fetch_addr_o=32'h0000_0104; first instruction is halfword 1 of that word, pc_o=32'h0000_0106.
REQ-037 ready_i=0 for 5 cycles with valid_o=1 -> outputs stable, count reaches 4, no fetch_req_o while count>2.
REQ-038 rst_i asserted in WAIT, response arrives the next cycle -> data dropped, valid_o=0, first post-reset fetch_addr_o=RESET_PC.
REQ-039 With INSTR_ALIGNER_COMPRESSED_EN undefined, word 32'h0001_4501 -> instr_o=32'h0001_4501, decompress_o=0, next pc_o=4.

Source files
------------

// File: rtl/instr_aligner.sv
// Instruction aligner: turns word fetches into a stream of whole 16/32-bit instructions.
// Define INSTR_ALIGNER_COMPRESSED_EN to enable 16-bit (compressed) instruction handling.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic        decompress_o,
    output logic [31:0] pc_o
);

`ifdef INSTR_ALIGNER_COMPRESSED_EN
    localparam logic        COMPRESSED = 1'b1;
    localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFF;
`else
    localparam logic        COMPRESSED = 1'b0;
    localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFD;
`endif

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DROP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0][15:0] buf_q, buf_d;
    logic [2:0]       count_q, count_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             skip_q, skip_d;

    logic             head16;
    logic             out_valid;
    logic             xfer;
    logic             req;
    logic             resp_take;
    logic [2:0]       pop_n;
    logic [2:0]       push_n;
    logic [2:0]       base;
    logic [3:0][15:0] shifted;

    always_comb begin
        head16    = COMPRESSED && (buf_q[0][1:0] != 2'b11);
        out_valid = !rst_i && (head16 ? (count_q >= 3'd1) : (count_q >= 3'd2));
    end

    assign valid_o      = out_valid;
    assign decompress_o = out_valid && head16;
    assign instr_o      = !out_valid ? '0 :
                          head16     ? {16'h0000, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign pc_o         = pc_q;
    assign fetch_addr_o = addr_q;
    assign fetch_req_o  = req;

    // A redirect that coincides with the response it would otherwise wait for
    // consumes that response here, so the FSM never waits on a reply already seen.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        resp_take = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (!rst_i && !redirect_i && (count_q <= 3'd2)) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fetch_valid_i) begin
                    state_d   = S_RUN;
                    resp_take = !redirect_i;
                end else if (redirect_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (fetch_valid_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        xfer   = out_valid && ready_i && !redirect_i;
        pop_n  = '0;
        push_n = '0;
        if (xfer) begin
            pop_n = head16 ? 3'd1 : 3'd2;
        end
        if (resp_take) begin
            push_n = skip_q ? 3'd1 : 3'd2;
        end

        shifted = buf_q;
        if (pop_n == 3'd1) begin
            shifted = {16'h0000, buf_q[3:1]};
        end else if (pop_n == 3'd2) begin
            shifted = {32'h0000_0000, buf_q[3:2]};
        end

        // New halfwords land right behind whatever survives this cycle's pop.
        base  = count_q - pop_n;
        buf_d = shifted;
        if (push_n != 3'd0) begin
            buf_d[base[1:0]] = skip_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
        end
        if (push_n == 3'd2) begin
            buf_d[base[1:0] + 2'd1] = fetch_data_i[31:16];
        end

        count_d = count_q - pop_n + push_n;
        pc_d    = xfer ? (pc_q + (head16 ? 32'd2 : 32'd4)) : pc_q;
        addr_d  = req ? (addr_q + 32'd4) : addr_q;
        skip_d  = resp_take ? 1'b0 : skip_q;

        if (redirect_i) begin
            count_d = '0;
            pc_d    = redirect_pc_i & PC_MASK;
            addr_d  = {redirect_pc_i[31:2], 2'b00};
            skip_d  = COMPRESSED && redirect_pc_i[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC & PC_MASK;
            addr_q  <= {RESET_PC[31:2], 2'b00};
            skip_q  <= COMPRESSED && RESET_PC[1];
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner; expectations follow INSTR_ALIGNER_COMPRESSED_EN.
module tb_instr_aligner;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef INSTR_ALIGNER_COMPRESSED_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_valid_i;
    logic [31:0] fetch_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic        decompress_o;
    logic [31:0] pc_o;

    logic        auto_valid, man_valid;
    logic [31:0] auto_data, man_data;
    bit          mem_auto;
    int          resp_delay;
    logic [31:0] mem [0:255];

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        dec;
    } exp_t;
    exp_t sb[$];

    assign fetch_valid_i = auto_valid | man_valid;
    assign fetch_data_i  = man_valid ? man_data : auto_data;

    always #5 clk_i = ~clk_i;

    instr_aligner #(.RESET_PC(RST_PC)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fetch_req_o  (fetch_req_o),
        .fetch_addr_o (fetch_addr_o),
        .fetch_valid_i(fetch_valid_i),
        .fetch_data_i (fetch_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .decompress_o (decompress_o),
        .pc_o         (pc_o)
    );

    // Memory model: answers each request resp_delay cycles later; a reset cancels it.
    initial begin : responder
        logic [31:0] ra;
        bit          ok;
        auto_valid = 1'b0;
        auto_data  = '0;
        forever begin
            @(negedge clk_i);
            if (mem_auto && fetch_req_o) begin
                ra = fetch_addr_o;
                ok = 1'b1;
                for (int k = 0; k < resp_delay; k++) begin
                    @(posedge clk_i);
                    if (rst_i) ok = 1'b0;
                end
                #1;
                if (ok && mem_auto) begin
                    auto_valid = 1'b1;
                    auto_data  = mem[ra[9:2]];
                    @(posedge clk_i);
                    #1;
                    auto_valid = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic push_expected(input logic [31:0] start_pc, input int n);
        logic [31:0] p;
        logic [15:0] lo;
        exp_t        e;
        p = CMP ? start_pc : (start_pc & 32'hFFFF_FFFD);
        for (int k = 0; k < n; k++) begin
            lo   = hw_at(p);
            e.pc = p;
            if (CMP && lo[1:0] != 2'b11) begin
                e.instr = {16'h0000, lo};
                e.dec   = 1'b1;
                p       = p + 32'd2;
            end else begin
                e.instr = {hw_at(p + 32'd2), lo};
                e.dec   = 1'b0;
                p       = p + 32'd4;
            end
            sb.push_back(e);
        end
    endtask

    task automatic load_prog;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h0001_4501;
        mem[1] = 32'h0513_8082;
        mem[2] = 32'h4581_0000;
        mem[3] = 32'h00A5_8593;
        mem[4] = 32'h0002_0002;
    endtask

    task automatic do_reset;
        rst_i      = 1'b1;
        man_valid  = 1'b0;
        redirect_i = 1'b0;
        sb.delete();
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        mem_auto = 1'b0;
        ready_i  = 1'b0;
        rst_i    = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        nvec++; if (fetch_req_o !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", fetch_req_o); end
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        nvec++; if (instr_o !== 32'h0) begin nerr++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
        nvec++; if (decompress_o !== 1'b0) begin nerr++; $display("FAIL rst_dec got=%b exp=0", decompress_o); end
        nvec++; if (pc_o !== RST_PC) begin nerr++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RST_PC); end
        nvec++; if (fetch_addr_o !== {RST_PC[31:2], 2'b00}) begin nerr++; $display("FAIL rst_addr got=%h exp=%h", fetch_addr_o, {RST_PC[31:2], 2'b00}); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        nvec++; if ({fetch_req_o, fetch_addr_o} !== {1'b1, RST_PC[31:2], 2'b00}) begin nerr++; $display("FAIL first_req got=%b/%h exp=1/%h", fetch_req_o, fetch_addr_o, RST_PC); end
    endtask

    task automatic test_basic;
        exp_t e;
        load_prog();
        mem_auto   = 1'b1;
        resp_delay = 1;
        ready_i    = 1'b0;
        do_reset();
        push_expected(RST_PC, CMP ? 2 : 1);
        @(negedge clk_i);
        @(negedge clk_i);
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got=%b exp=0", valid_o); end
        @(negedge clk_i);
        nvec++; if (valid_o !== 1'b1) begin nerr++; $display("FAIL basic_latency got=%b exp=1", valid_o); end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        for (int c = 0; c < 50 && sb.size() != 0; c++) begin
            @(negedge clk_i);
            if (valid_o && ready_i && !redirect_i) begin
                e = sb.pop_front();
                nvec++;
                if ({instr_o, pc_o, decompress_o} !== {e.instr, e.pc, e.dec}) begin
                    nerr++;
                    $display("FAIL basic_instr got=%h@%h d%b exp=%h@%h d%b", instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
                end
            end
            @(posedge clk_i);
            #1;
        end
        if (sb.size() != 0) begin nvec++; nerr++; $display("FAIL basic_timeout left=%0d exp=0", sb.size()); end
        @(negedge clk_i);
        nvec++; if (pc_o !== 32'd4) begin nerr++; $display("FAIL basic_next_pc got=%h exp=4", pc_o); end
    endtask

    task automatic test_split;
        exp_t e;
        load_prog();
        mem[0]   = 32'h0093_4501;
        mem[1]   = 32'h0000_0000;
        mem_auto = 1'b0;
        ready_i  = 1'b1;
        do_reset();
        push_expected(RST_PC, 2);
        @(negedge clk_i);
        nvec++; if ({fetch_req_o, fetch_addr_o} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL split_req0 got=%b/%h exp=1/0", fetch_req_o, fetch_addr_o); end
        @(posedge clk_i); #1; man_valid = 1'b1; man_data = mem[0];
        @(posedge clk_i); #1; man_valid = 1'b0;
        @(negedge clk_i);
        e = sb.pop_front();
        nvec++;
        if ({valid_o, instr_o, pc_o, decompress_o} !== {1'b1, e.instr, e.pc, e.dec}) begin
            nerr++;
            $display("FAIL split_first got=%b %h@%h d%b exp=1 %h@%h d%b", valid_o, instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
        end
        nvec++; if ({fetch_req_o, fetch_addr_o} !== {1'b1, 32'h4}) begin nerr++; $display("FAIL split_req1 got=%b/%h exp=1/4", fetch_req_o, fetch_addr_o); end
        @(posedge clk_i); #1;
        repeat (3) begin
            @(negedge clk_i);
            nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL split_hidden got=%b exp=0", valid_o); end
            @(posedge clk_i); #1;
        end
        man_valid = 1'b1; man_data = mem[1];
        @(posedge clk_i); #1; man_valid = 1'b0;
        @(negedge clk_i);
        e = sb.pop_front();
        nvec++;
        if ({valid_o, instr_o, pc_o, decompress_o} !== {1'b1, e.instr, e.pc, e.dec}) begin
            nerr++;
            $display("FAIL split_second got=%b %h@%h d%b exp=1 %h@%h d%b", valid_o, instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
        end
    endtask

    task automatic test_redirect;
        exp_t e;
        bit   got_req;
        load_prog();
        mem[0]     = 32'hDEAD_BEEF;
        mem[65]    = 32'h8082_1234;
        mem[66]    = 32'h0001_0001;
        mem[67]    = 32'h0000_4501;
        mem_auto   = 1'b1;
        resp_delay = 3;
        ready_i    = 1'b1;
        do_reset();
        push_expected(32'h0000_0106, 3);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0106;
        @(negedge clk_i);
        nvec++; if (fetch_req_o !== 1'b0) begin nerr++; $display("FAIL redir_req got=%b exp=0", fetch_req_o); end
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL redir_valid got=%b exp=0", valid_o); end
        got_req = 1'b0;
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk_i);
            if (fetch_req_o && !got_req) begin
                got_req = 1'b1;
                nvec++; if (fetch_addr_o !== 32'h0000_0104) begin nerr++; $display("FAIL redir_addr got=%h exp=00000104", fetch_addr_o); end
            end
            if (valid_o && ready_i && !redirect_i) begin
                e = sb.pop_front();
                nvec++;
                if ({instr_o, pc_o, decompress_o} !== {e.instr, e.pc, e.dec}) begin
                    nerr++;
                    $display("FAIL redir_instr got=%h@%h d%b exp=%h@%h d%b", instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
                end
            end
            @(posedge clk_i); #1;
        end
        if (!got_req) begin nvec++; nerr++; $display("FAIL redir_no_req got=0 exp=1"); end
        if (sb.size() != 0) begin nvec++; nerr++; $display("FAIL redir_timeout left=%0d exp=0", sb.size()); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   nreq;
        load_prog();
        mem_auto   = 1'b1;
        resp_delay = 1;
        ready_i    = 1'b0;
        do_reset();
        push_expected(RST_PC, 5);
        nreq = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (fetch_req_o) nreq++;
            if (c >= 2) begin
                nvec++;
                if ({valid_o, instr_o, pc_o, decompress_o} !== {1'b1, sb[0].instr, sb[0].pc, sb[0].dec}) begin
                    nerr++;
                    $display("FAIL bp_hold c=%0d got=%b %h@%h d%b exp=1 %h@%h d%b", c, valid_o, instr_o, pc_o, decompress_o, sb[0].instr, sb[0].pc, sb[0].dec);
                end
            end
        end
        nvec++; if (nreq !== 2) begin nerr++; $display("FAIL bp_req_count got=%0d exp=2", nreq); end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        for (int c = 0; c < 80 && sb.size() != 0; c++) begin
            @(negedge clk_i);
            if (valid_o && ready_i && !redirect_i) begin
                e = sb.pop_front();
                nvec++;
                if ({instr_o, pc_o, decompress_o} !== {e.instr, e.pc, e.dec}) begin
                    nerr++;
                    $display("FAIL bp_instr got=%h@%h d%b exp=%h@%h d%b", instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
                end
            end
            @(posedge clk_i); #1;
        end
        if (sb.size() != 0) begin nvec++; nerr++; $display("FAIL bp_timeout left=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_mid_fetch;
        load_prog();
        mem_auto = 1'b0;
        ready_i  = 1'b1;
        do_reset();
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (fetch_req_o !== 1'b0) begin nerr++; $display("FAIL rmf_req_in_rst got=%b exp=0", fetch_req_o); end
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        man_valid = 1'b1;
        man_data  = 32'h0000_4501;
        @(negedge clk_i);
        nvec++; if ({fetch_req_o, fetch_addr_o} !== {1'b1, RST_PC[31:2], 2'b00}) begin nerr++; $display("FAIL rmf_first_req got=%b/%h exp=1/%h", fetch_req_o, fetch_addr_o, RST_PC); end
        @(posedge clk_i); #1;
        man_valid = 1'b0;
        @(negedge clk_i);
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL rmf_dropped got=%b exp=0", valid_o); end
    endtask

    task automatic test_stream;
        exp_t        e;
        logic [31:0] rpc;
        load_prog();
        for (int i = 5; i < 256; i++) mem[i] = $urandom();
        mem_auto   = 1'b1;
        resp_delay = 2;
        ready_i    = 1'b1;
        do_reset();
        push_expected(RST_PC, 60);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            if (valid_o && ready_i && !redirect_i) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL stream_extra got=%h@%h exp=none", instr_o, pc_o);
                end else begin
                    e = sb.pop_front();
                    if ({instr_o, pc_o, decompress_o} !== {e.instr, e.pc, e.dec}) begin
                        nerr++;
                        $display("FAIL stream_instr got=%h@%h d%b exp=%h@%h d%b", instr_o, pc_o, decompress_o, e.instr, e.pc, e.dec);
                    end
                end
            end
            @(posedge clk_i); #1;
            redirect_i = 1'b0;
            if (c == 30 || c == 90) begin
                rpc           = 32'($urandom_range(0, 255)) << 1;
                redirect_i    = 1'b1;
                redirect_pc_i = rpc;
                sb.delete();
                push_expected(rpc, (c == 30) ? 60 : 25);
            end
            ready_i = ($urandom_range(0, 99) < 70);
            if (c > 90 && sb.size() == 0) break;
        end
        redirect_i = 1'b0;
        if (sb.size() != 0) begin nvec++; nerr++; $display("FAIL stream_timeout left=%0d exp=0", sb.size()); end
    endtask

    initial begin
        rst_i         = 1'b1;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        man_valid     = 1'b0;
        man_data      = '0;
        mem_auto      = 1'b0;
        resp_delay    = 1;
        load_prog();
        test_reset();
        test_basic();
        test_split();
        test_redirect();
        test_backpressure();
        test_reset_mid_fetch();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
